udp_rx: RTL and testbench
=========================

// Module: udp_rx
// PURPOSE
//  GMII-side UDP/IPv4 receiver, counterpart of the UDP transmitter. Parses preamble/SFD,
//  Ethernet, IPv4 and UDP headers byte-by-byte from gmii_rxd. Filters on MAC/IP/protocol and
//  streams the UDP payload out as bytes with a per-packet done pulse and byte count.
//  Sits between the GMII RX pins (rx clock domain) and the user payload sink. FCS is not checked.
// PARAMETERS
//  BOARD_MAC  48'h00_11_22_33_44_55  accepted destination MAC (48'hFF_FF_FF_FF_FF_FF also accepted)
//  BOARD_IP   {8'd192,8'd168,8'd1,8'd123}  accepted destination IP
// PORTS
//  clk           in   1   GMII RX clock
//  rst_n         in   1   asynchronous, active-low reset
//  gmii_rx_dv    in   1   GMII receive data valid
//  gmii_rxd      in   8   GMII receive data
//  rec_en        out  1   payload byte valid (1 cycle per byte)
//  rec_data      out  8   payload byte
//  rec_pkt_done  out  1   1-cycle pulse, coincident with last payload rec_en
//  rec_byte_num  out  16  payload length (UDP length - 8), valid from rec_pkt_done until next done
//  src_mac       out  48  source MAC of last accepted frame (updated at UDP header end)
//  src_ip        out  32  source IP of last accepted frame (updated at UDP header end)
// BEHAVIOUR
//  Reset: all outputs 0; FSM in ST_IDLE; all counters 0.
//  Inputs sampled on posedge clk. Outputs are registered. A payload byte sampled at edge k
//  appears on rec_data/rec_en after edge k.
//  FSM (one-hot): ST_IDLE, ST_PREAMBLE, ST_ETH_HEAD, ST_IP_HEAD, ST_UDP_HEAD, ST_RX_DATA, ST_RX_END.
//  - IDLE: dv&&rxd==8'h55 -> PREAMBLE (count=1).
//  - PREAMBLE: requires exactly 7 x 8'h55, then 8'hD5 -> ETH_HEAD. Any other byte -> RX_END.
//  - ETH_HEAD: 14 bytes, cnt 0..13. Bytes 0-5 are dest MAC, compared to BOARD_MAC or all-ones.
//    Bytes 6-11 are src MAC (staged). Bytes 12-13 must equal 16'h0800.
//    At byte 13: all ok -> IP_HEAD, else RX_END.
//  - IP_HEAD: 20 bytes. Byte0 must be 8'h45, checked immediately (fail -> RX_END).
//    Byte9 must be 8'd17, checked immediately. Bytes 12-15 are src IP (staged).
//    Bytes 16-19 are dest IP; compared to BOARD_IP at byte 19 (ok -> UDP_HEAD, else RX_END).
//    Header checksum not verified.
//  - UDP_HEAD: 8 bytes. Bytes 4-5 are UDP length L (big-endian). At byte 7:
//    L<8 -> RX_END, no done.
//    L==8 -> rec_pkt_done pulse with rec_byte_num=0, no rec_en, src_mac/src_ip commit -> RX_END.
//    Otherwise commit src_mac/src_ip, load payload count L-8 (16-bit) -> RX_DATA.
//  - RX_DATA: each dv byte asserts rec_en. On byte L-8 (last), also assert rec_pkt_done and load
//    rec_byte_num=L-8, then -> RX_END. Trailing pad/FCS bytes are never output.
//  - RX_END: wait while dv=1. dv=0 -> IDLE.
//  dv low in any state other than IDLE/RX_END: abort -> IDLE next cycle. No rec_pkt_done.
//  Bytes already emitted stay emitted; rec_byte_num unchanged.
//  dv gaps inside a frame are not supported; a gap is treated as frame end.
//  Back-to-back frames: minimum 1 dv-low cycle between frames is sufficient to re-arm.
//  rst_n asserted mid-frame: immediate return to reset state. Remainder of frame ignored until
//  dv low then a new preamble.
// TESTING
//  1 Unicast frame to BOARD_MAC/BOARD_IP, proto 17, L=12, payload 01 02 03 04
//    -> 4 rec_en pulses, rec_data 01..04, done with last byte, rec_byte_num=4.
//  2 Broadcast dest MAC, L=26 (18 B payload) + FCS -> 18 bytes out, rec_byte_num=18,
//    FCS bytes not emitted.
//  3 Reject cases, each separately: dest MAC 00..01, type 0x0806, proto 6, dest IP .102, byte0 0x46
//    -> zero rec_en, no done, src_mac/src_ip unchanged.
//  4 dv dropped after 2 of 10 payload bytes -> 2 rec_en, no done. A following valid frame
//    (L=9, byte AA) -> 1 byte AA, done, rec_byte_num=1.
//  5 Preamble with 6 x 55 then D5, and a frame with L=8
//    -> first frame dropped; second frame gives done pulse with rec_byte_num=0, no rec_en.
//  6 rst_n pulse during IP header, frame continues -> no output. Next valid frame received correctly.

Source files
------------

// File: rtl/udp_rx_if.sv
// GMII receive bus and UDP payload stream toward the user sink.
// Ports: gmii_rx_dv/gmii_rxd in; rec_*/src_mac/src_ip out.
interface udp_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output rec_en, rec_data, rec_pkt_done,
        output rec_byte_num, src_mac, src_ip
    );

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  rec_en, rec_data, rec_pkt_done,
        input  rec_byte_num, src_mac, src_ip
    );
endinterface

// File: rtl/udp_rx.sv
// GMII UDP/IPv4 receiver: parses preamble, Ethernet, IPv4, UDP headers.
// Ports: clk, rst_n (async low), rx (udp_rx_if.slave) bus/payload.
module udp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic    clk,
    input  logic    rst_n,
    udp_rx_if.slave rx
);

    typedef enum logic [6:0] {
        ST_IDLE     = 7'b000_0001,
        ST_PREAMBLE = 7'b000_0010,
        ST_ETH_HEAD = 7'b000_0100,
        ST_IP_HEAD  = 7'b000_1000,
        ST_UDP_HEAD = 7'b001_0000,
        ST_RX_DATA  = 7'b010_0000,
        ST_RX_END   = 7'b100_0000
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        dv_q;
    logic [47:0] dmac_q;
    logic [47:0] smac_q;
    logic [7:0]  type_hi_q;
    logic [31:0] sip_q;
    logic [31:0] dip_q;
    logic [15:0] len_q;
    logic [15:0] pay_len_q;
    logic [15:0] left_q;
    logic        rec_en_q;
    logic [7:0]  rec_data_q;
    logic        done_q;
    logic [15:0] byte_num_q;
    logic [47:0] src_mac_q;
    logic [31:0] src_ip_q;

    logic       dv;
    logic [7:0] rxd;
    logic       mac_ok;

    assign dv     = rx.gmii_rx_dv;
    assign rxd    = rx.gmii_rxd;
    assign mac_ok = (dmac_q == BOARD_MAC) || (dmac_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            // Held high so a frame already in flight at reset
            // is ignored until the line goes idle.
            dv_q       <= 1'b1;
            dmac_q     <= '0;
            smac_q     <= '0;
            type_hi_q  <= '0;
            sip_q      <= '0;
            dip_q      <= '0;
            len_q      <= '0;
            pay_len_q  <= '0;
            left_q     <= '0;
            rec_en_q   <= 1'b0;
            rec_data_q <= '0;
            done_q     <= 1'b0;
            byte_num_q <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
        end else begin
            dv_q     <= dv;
            rec_en_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (dv && rxd == 8'h55 && !dv_q) begin
                        state_q <= ST_PREAMBLE;
                        cnt_q   <= 5'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end else if (rxd == 8'h55 && cnt_q < 5'd7) begin
                        cnt_q <= cnt_q + 5'd1;
                    end else if (rxd == 8'hD5 && cnt_q == 5'd7) begin
                        state_q <= ST_ETH_HEAD;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_RX_END;
                    end
                end
                ST_ETH_HEAD: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q < 5'd6) begin
                            dmac_q <= {dmac_q[39:0], rxd};
                        end else if (cnt_q < 5'd12) begin
                            smac_q <= {smac_q[39:0], rxd};
                        end else if (cnt_q == 5'd12) begin
                            type_hi_q <= rxd;
                        end else begin
                            cnt_q <= '0;
                            if (mac_ok && {type_hi_q, rxd} == 16'h0800) begin
                                state_q <= ST_IP_HEAD;
                            end else begin
                                state_q <= ST_RX_END;
                            end
                        end
                    end
                end
                ST_IP_HEAD: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd0 && rxd != 8'h45) begin
                            state_q <= ST_RX_END;
                        end
                        if (cnt_q == 5'd9 && rxd != 8'd17) begin
                            state_q <= ST_RX_END;
                        end
                        if (cnt_q >= 5'd12 && cnt_q <= 5'd15) begin
                            sip_q <= {sip_q[23:0], rxd};
                        end
                        if (cnt_q >= 5'd16 && cnt_q <= 5'd18) begin
                            dip_q <= {dip_q[23:0], rxd};
                        end
                        if (cnt_q == 5'd19) begin
                            cnt_q <= '0;
                            if ({dip_q[23:0], rxd} == BOARD_IP) begin
                                state_q <= ST_UDP_HEAD;
                            end else begin
                                state_q <= ST_RX_END;
                            end
                        end
                    end
                end
                ST_UDP_HEAD: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd4 || cnt_q == 5'd5) begin
                            len_q <= {len_q[7:0], rxd};
                        end
                        if (cnt_q == 5'd7) begin
                            cnt_q <= '0;
                            if (len_q < 16'd8) begin
                                state_q <= ST_RX_END;
                            end else begin
                                src_mac_q <= smac_q;
                                src_ip_q  <= sip_q;
                                if (len_q == 16'd8) begin
                                    // Empty datagram: report it, nothing to stream.
                                    done_q     <= 1'b1;
                                    byte_num_q <= '0;
                                    state_q    <= ST_RX_END;
                                end else begin
                                    pay_len_q <= len_q - 16'd8;
                                    left_q    <= len_q - 16'd8;
                                    state_q   <= ST_RX_DATA;
                                end
                            end
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rec_en_q   <= 1'b1;
                        rec_data_q <= rxd;
                        if (left_q == 16'd1) begin
                            done_q     <= 1'b1;
                            byte_num_q <= pay_len_q;
                            state_q    <= ST_RX_END;
                        end else begin
                            left_q <= left_q - 16'd1;
                        end
                    end
                end
                ST_RX_END: begin
                    if (!dv) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx.rec_en       = rec_en_q;
    assign rx.rec_data     = rec_data_q;
    assign rx.rec_pkt_done = done_q;
    assign rx.rec_byte_num = byte_num_q;
    assign rx.src_mac      = src_mac_q;
    assign rx.src_ip       = src_ip_q;

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: builds GMII frames, checks payload stream.
// Ports: none (top-level bench).
module tb_udp_rx;

    localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] BIP  = 32'hC0_A8_01_7B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    udp_rx_if u_if ();

    udp_rx u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (u_if.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    int          en_cnt;
    int          done_cnt;
    int          done_en;
    logic [7:0]  got_b[$];

    always @(negedge clk) begin
        if (u_if.rec_en) begin
            en_cnt++;
            got_b.push_back(u_if.rec_data);
        end
        if (u_if.rec_pkt_done) begin
            done_cnt++;
            if (u_if.rec_en) done_en++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        en_cnt   = 0;
        done_cnt = 0;
        done_en  = 0;
        got_b.delete();
    endtask

    function automatic logic [63:0] byte_at(input int i);
        if (i < got_b.size()) return {56'd0, got_b[i]};
        return 64'hDEAD;
    endfunction

    task automatic send(input int npre, input logic [47:0] dmac,
                        input logic [47:0] smac, input logic [15:0] etype,
                        input logic [7:0] ver, input logic [7:0] proto,
                        input logic [31:0] sip, input logic [31:0] dip,
                        input logic [15:0] ulen, input int npay,
                        input logic [7:0] pbase, input int ntrail,
                        input int rst_at);
        logic [7:0]  f[$];
        logic [15:0] tl;
        tl = ulen + 16'd20;
        for (int i = 0; i < npre; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(dmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(smac[47-8*i -: 8]);
        f.push_back(etype[15:8]);
        f.push_back(etype[7:0]);
        f.push_back(ver);
        f.push_back(8'h00);
        f.push_back(tl[15:8]);
        f.push_back(tl[7:0]);
        f.push_back(8'h12);
        f.push_back(8'h34);
        f.push_back(8'h40);
        f.push_back(8'h00);
        f.push_back(8'h40);
        f.push_back(proto);
        f.push_back(8'h00);
        f.push_back(8'h00);
        for (int i = 0; i < 4; i++) f.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(dip[31-8*i -: 8]);
        f.push_back(8'h04);
        f.push_back(8'hD2);
        f.push_back(8'h16);
        f.push_back(8'h2E);
        f.push_back(ulen[15:8]);
        f.push_back(ulen[7:0]);
        f.push_back(8'h00);
        f.push_back(8'h00);
        for (int i = 0; i < npay; i++) f.push_back(pbase + 8'(i));
        for (int i = 0; i < ntrail; i++) f.push_back(8'hF0 + 8'(i));
        foreach (f[i]) begin
            @(negedge clk);
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            u_if.gmii_rx_dv = 1'b1;
            u_if.gmii_rxd   = f[i];
        end
        @(negedge clk);
        rst_n = 1'b1;
        u_if.gmii_rx_dv = 1'b0;
        u_if.gmii_rxd   = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    localparam logic [47:0] SMAC1 = 48'h0A_0B_0C_0D_0E_01;
    localparam logic [47:0] SMAC2 = 48'h0A_0B_0C_0D_0E_02;
    localparam logic [47:0] SMAC3 = 48'h0A_0B_0C_0D_0E_03;
    localparam logic [31:0] SIP1  = 32'hC0_A8_01_64;
    localparam logic [31:0] SIP2  = 32'hC0_A8_01_65;
    localparam logic [31:0] SIP3  = 32'hC0_A8_01_66;

    initial begin
        logic [47:0] dm;
        logic [15:0] et;
        logic [7:0]  vr;
        logic [7:0]  pr;
        logic [31:0] di;
        u_if.gmii_rx_dv = 1'b0;
        u_if.gmii_rxd   = 8'h00;
        clr();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_en", u_if.rec_en, 0);
        chk("rst_data", u_if.rec_data, 0);
        chk("rst_done", u_if.rec_pkt_done, 0);
        chk("rst_num", u_if.rec_byte_num, 0);
        chk("rst_mac", u_if.src_mac, 0);
        chk("rst_ip", u_if.src_ip, 0);

        // 1: unicast, 4 payload bytes
        clr();
        send(7, BMAC, SMAC1, 16'h0800, 8'h45, 8'd17, SIP1, BIP,
             16'd12, 4, 8'h01, 0, -1);
        chk("t1_en", en_cnt, 4);
        chk("t1_done", done_cnt, 1);
        chk("t1_done_last", done_en, 1);
        chk("t1_num", u_if.rec_byte_num, 4);
        for (int i = 0; i < 4; i++) chk("t1_byte", byte_at(i), i + 1);
        chk("t1_mac", u_if.src_mac, SMAC1);
        chk("t1_ip", u_if.src_ip, SIP1);

        // 2: broadcast, 18 payload bytes then FCS
        clr();
        send(7, BCST, SMAC2, 16'h0800, 8'h45, 8'd17, SIP2, BIP,
             16'd26, 18, 8'h10, 4, -1);
        chk("t2_en", en_cnt, 18);
        chk("t2_done", done_cnt, 1);
        chk("t2_num", u_if.rec_byte_num, 18);
        for (int i = 0; i < 18; i++) chk("t2_byte", byte_at(i), 8'h10 + i);
        chk("t2_mac", u_if.src_mac, SMAC2);
        chk("t2_ip", u_if.src_ip, SIP2);

        // 3: reject cases
        for (int k = 0; k < 5; k++) begin
            dm = BMAC;
            et = 16'h0800;
            vr = 8'h45;
            pr = 8'd17;
            di = BIP;
            case (k)
                0: dm = 48'h00_00_00_00_00_01;
                1: et = 16'h0806;
                2: pr = 8'd6;
                3: di = 32'hC0_A8_01_66;
                default: vr = 8'h46;
            endcase
            clr();
            send(7, dm, SMAC3, et, vr, pr, SIP3, di,
                 16'd12, 4, 8'h01, 0, -1);
            chk("t3_en", en_cnt, 0);
            chk("t3_done", done_cnt, 0);
            chk("t3_mac", u_if.src_mac, SMAC2);
            chk("t3_ip", u_if.src_ip, SIP2);
        end

        // 4: truncated payload, then a good one-byte frame
        clr();
        send(7, BMAC, SMAC1, 16'h0800, 8'h45, 8'd17, SIP1, BIP,
             16'd18, 2, 8'h30, 0, -1);
        chk("t4_en", en_cnt, 2);
        chk("t4_done", done_cnt, 0);
        chk("t4_num", u_if.rec_byte_num, 18);
        clr();
        send(7, BMAC, SMAC1, 16'h0800, 8'h45, 8'd17, SIP1, BIP,
             16'd9, 1, 8'hAA, 0, -1);
        chk("t4b_en", en_cnt, 1);
        chk("t4b_byte", byte_at(0), 8'hAA);
        chk("t4b_done", done_cnt, 1);
        chk("t4b_num", u_if.rec_byte_num, 1);

        // 5: short preamble dropped; empty datagram reported
        clr();
        send(6, BMAC, SMAC2, 16'h0800, 8'h45, 8'd17, SIP2, BIP,
             16'd12, 4, 8'h01, 0, -1);
        chk("t5_en", en_cnt, 0);
        chk("t5_done", done_cnt, 0);
        chk("t5_mac", u_if.src_mac, SMAC1);
        clr();
        send(7, BMAC, SMAC2, 16'h0800, 8'h45, 8'd17, SIP2, BIP,
             16'd8, 0, 8'h00, 4, -1);
        chk("t5b_en", en_cnt, 0);
        chk("t5b_done", done_cnt, 1);
        chk("t5b_num", u_if.rec_byte_num, 0);
        chk("t5b_mac", u_if.src_mac, SMAC2);
        chk("t5b_ip", u_if.src_ip, SIP2);

        // 6: reset pulse in IP header, then a good frame
        clr();
        send(7, BMAC, SMAC3, 16'h0800, 8'h45, 8'd17, SIP3, BIP,
             16'd12, 4, 8'h01, 0, 27);
        chk("t6_en", en_cnt, 0);
        chk("t6_done", done_cnt, 0);
        chk("t6_mac", u_if.src_mac, 0);
        chk("t6_num", u_if.rec_byte_num, 0);
        clr();
        send(7, BMAC, SMAC3, 16'h0800, 8'h45, 8'd17, SIP3, BIP,
             16'd11, 3, 8'h70, 0, -1);
        chk("t6b_en", en_cnt, 3);
        chk("t6b_done", done_cnt, 1);
        chk("t6b_num", u_if.rec_byte_num, 3);
        chk("t6b_byte", byte_at(2), 8'h72);
        chk("t6b_mac", u_if.src_mac, SMAC3);
        chk("t6b_ip", u_if.src_ip, SIP3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
